// File: rtl/pc_stack_counter.sv
// rtl/pc_stack_counter.sv - VeriRISC fetch-stage program counter with skip, jump and call/return stack
// Optional return-address stack is built only when PC_RET_STACK_EN is defined.
module pc_stack_counter #(
    parameter int               WIDTH     = 5,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enab,
    input  logic                       skip,
    input  logic                       load,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           pc_in,
    output logic [WIDTH-1:0]           pc_out,
    output logic [$clog2(DEPTH+1)-1:0] sp_level,
    output logic                       stk_full,
    output logic                       stk_empty,
    output logic                       stk_err
);

    localparam int SPW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] pc_plus2;

    // Natural WIDTH-bit overflow gives the modulo 2**WIDTH wrap.
    assign pc_plus1 = pc_q + WIDTH'(1);
    assign pc_plus2 = pc_q + WIDTH'(2);

`ifdef PC_RET_STACK_EN
    localparam int             AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [SPW-1:0]   sp_dec;
    logic             err_q;
    logic             err_d;
    logic             push;

    assign sp_dec = sp_q - SPW'(1);

    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (ret) begin
            if (sp_q != '0) begin
                pc_d = stack_q[sp_dec[AW-1:0]];
                sp_d = sp_dec;
            end else begin
                err_d = 1'b1;
            end
        end else if (call) begin
            // Overflowing call is dropped entirely: no push and no jump.
            if (sp_q != SP_MAX) begin
                push = 1'b1;
                pc_d = pc_in;
                sp_d = sp_q + SPW'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (load) begin
            pc_d = pc_in;
        end else if (skip) begin
            pc_d = pc_plus2;
        end else if (enab) begin
            pc_d = pc_plus1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Entries are never cleared; anything at or above sp_q is stale.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_q[sp_q[AW-1:0]] <= pc_plus1;
        end
    end

    assign sp_level  = sp_q;
    assign stk_full  = (sp_q == SP_MAX);
    assign stk_empty = (sp_q == '0);
    assign stk_err   = err_q;
`else
    logic unused_ret;
    assign unused_ret = ret;

    // Without a stack, call is an ordinary jump and ret falls through.
    always_comb begin
        pc_d = pc_q;
        if (call || load) begin
            pc_d = pc_in;
        end else if (skip) begin
            pc_d = pc_plus2;
        end else if (enab) begin
            pc_d = pc_plus1;
        end
    end

    assign sp_level  = '0;
    assign stk_full  = 1'b0;
    assign stk_empty = 1'b1;
    assign stk_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_pc_stack_counter.sv
// tb/tb_pc_stack_counter.sv - vector table, corner sequences and randomized model check for pc_stack_counter
module tb_pc_stack_counter;

    localparam int WIDTH = 5;
    localparam int DEPTH = 4;
    localparam int RV    = 3;
`ifdef PC_RET_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enab = 1'b0;
    logic             skip = 1'b0;
    logic             load = 1'b0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic [WIDTH-1:0] pc_in = '0;
    logic [WIDTH-1:0] pc_out;
    logic [2:0]       sp_level;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_err;

    int passed = 0;
    int total  = 0;

    pc_stack_counter #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_VEC(5'd3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enab     (enab),
        .skip     (skip),
        .load     (load),
        .call     (call),
        .ret      (ret),
        .pc_in    (pc_in),
        .pc_out   (pc_out),
        .sp_level (sp_level),
        .stk_full (stk_full),
        .stk_empty(stk_empty),
        .stk_err  (stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        bit         r, e, s, l, c, rt;
        logic [4:0] pin;
        logic [4:0] epc;
        logic [2:0] esp;
        bit         eerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, bit r, bit e, bit s, bit l, bit c, bit rt,
                                int pin, int epc, int esp, bit eerr);
        vec_t v;
        v.nm = nm; v.r = r; v.e = e; v.s = s; v.l = l; v.c = c; v.rt = rt;
        v.pin = 5'(pin); v.epc = 5'(epc); v.esp = 3'(esp); v.eerr = eerr;
        return v;
    endfunction

    task automatic step(bit r, bit e, bit s, bit l, bit c, bit rt, int pin);
        @(negedge clk);
        rst = r; enab = e; skip = s; load = l; call = c; ret = rt; pc_in = 5'(pin);
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, int epc, int esp, bit eerr);
        logic [10:0] exp_v;
        logic [10:0] act_v;
        exp_v = {5'(epc), 3'(esp), (esp == DEPTH), (esp == 0), eerr};
        act_v = {pc_out, sp_level, stk_full, stk_empty, stk_err};
        total++;
        if (act_v !== exp_v)
            $display("FAIL %s: got pc=%0d sp=%0d full=%b empty=%b err=%b, want pc=%0d sp=%0d full=%b empty=%b err=%b",
                     nm, pc_out, sp_level, stk_full, stk_empty, stk_err,
                     epc, esp, (esp == DEPTH), (esp == 0), eerr);
        else
            passed++;
    endtask

    // Reference model: integer pc, queue as the LIFO.
    int m_pc;
    int m_q[$];
    bit m_err;

    function automatic void model(bit r, bit e, bit s, bit l, bit c, bit rt, int pin);
        if (r) begin
            m_pc = RV; m_q.delete(); m_err = 0;
        end else if (STK && rt) begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else m_err = 1;
        end else if (c) begin
            if (!STK) m_pc = pin;
            else if (m_q.size() < DEPTH) begin
                m_q.push_back((m_pc + 1) % 32);
                m_pc = pin;
            end else m_err = 1;
        end else if (l) m_pc = pin;
        else if (s) m_pc = (m_pc + 2) % 32;
        else if (e) m_pc = (m_pc + 1) % 32;
    endfunction

    initial begin
        tbl.push_back(mk("reset",          1,0,0,0,0,0,  0,  3, 0, 0));
        tbl.push_back(mk("idle_hold",      0,0,0,0,0,0,  0,  3, 0, 0));
        tbl.push_back(mk("enab",           0,1,0,0,0,0,  0,  4, 0, 0));
        tbl.push_back(mk("load30",         0,0,0,1,0,0, 30, 30, 0, 0));
        tbl.push_back(mk("enab_31",        0,1,0,0,0,0,  0, 31, 0, 0));
        tbl.push_back(mk("enab_wrap",      0,1,0,0,0,0,  0,  0, 0, 0));
        tbl.push_back(mk("load31",         0,0,0,1,0,0, 31, 31, 0, 0));
        tbl.push_back(mk("skip_wrap31",    0,0,1,0,0,0,  0,  1, 0, 0));
        tbl.push_back(mk("load30b",        0,0,0,1,0,0, 30, 30, 0, 0));
        tbl.push_back(mk("skip_wrap30",    0,0,1,0,0,0,  0,  0, 0, 0));
        tbl.push_back(mk("load_over_skip", 0,1,1,1,0,0,  7,  7, 0, 0));
        tbl.push_back(mk("skip_over_enab", 0,1,1,0,0,0,  0,  9, 0, 0));
        tbl.push_back(mk("ret_empty",      0,0,0,0,0,1,  0,  9, 0, STK));
        tbl.push_back(mk("ret_enab_empty", 0,1,0,0,0,1,  0, STK ? 9 : 10, 0, STK));
        tbl.push_back(mk("reset_priority", 1,1,1,1,1,1, 12,  3, 0, 0));
        tbl.push_back(mk("call9",          0,0,0,0,1,0,  9,  9, STK ? 1 : 0, 0));
        tbl.push_back(mk("ret_after_call", 0,0,0,0,0,1,  0, STK ? 4 : 9, 0, 0));
        tbl.push_back(mk("call_over_load", 0,0,0,1,1,0, 17, 17, STK ? 1 : 0, 0));
        tbl.push_back(mk("reset_clears",   1,0,0,0,0,0,  0,  3, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].l, tbl[i].c, tbl[i].rt, int'(tbl[i].pin));
            check(tbl[i].nm, int'(tbl[i].epc), int'(tbl[i].esp), tbl[i].eerr);
        end

`ifdef PC_RET_STACK_EN
        // call / ret round trip
        step(0,0,0,1,0,0, 5);   check("cr_load5", 5, 0, 0);
        step(0,0,0,0,1,0, 20);  check("cr_call20", 20, 1, 0);
        step(0,1,0,0,0,0, 0);   check("cr_enab", 21, 1, 0);
        step(0,0,0,0,0,1, 0);   check("cr_ret", 6, 0, 0);
        // overflow then LIFO unwind
        step(1,0,0,0,0,0, 0);   check("ov_reset", 3, 0, 0);
        step(0,0,0,1,0,0, 0);   check("ov_load0", 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0,0,0,0,1,0, 10 + k);
            check($sformatf("ov_call%0d", k), 10 + k, k + 1, 0);
        end
        step(0,0,0,0,1,0, 14);  check("ov_call_full", 13, 4, 1);
        step(0,0,0,0,0,1, 0);   check("ov_ret1", 13, 3, 1);
        step(0,0,0,0,0,1, 0);   check("ov_ret2", 12, 2, 1);
        step(0,0,0,0,0,1, 0);   check("ov_ret3", 11, 1, 1);
        step(0,0,0,0,0,1, 0);   check("ov_ret4", 1, 0, 1);
        // underflow and pop priority
        step(1,0,0,0,0,0, 0);   check("un_reset", 3, 0, 0);
        step(0,0,0,0,0,1, 0);   check("un_ret_empty", 3, 0, 1);
        step(1,0,0,0,0,0, 0);   check("pr_reset", 3, 0, 0);
        step(0,0,0,1,0,0, 8);   check("pr_load8", 8, 0, 0);
        step(0,0,0,0,1,0, 20);  check("pr_call20", 20, 1, 0);
        step(0,1,0,1,0,1, 2);   check("pr_ret_wins", 9, 0, 0);
`else
        step(1,0,0,0,0,0, 0);   check("off_reset", 3, 0, 0);
        step(0,0,0,0,1,0, 9);   check("off_call9", 9, 0, 0);
        step(0,0,0,0,0,1, 0);   check("off_ret_ignored", 9, 0, 0);
        step(0,0,1,0,0,1, 0);   check("off_ret_skip", 11, 0, 0);
        step(0,0,0,0,1,1, 25);  check("off_call_ret", 25, 0, 0);
`endif

        step(1,0,0,0,0,0, 0);
        model(1,0,0,0,0,0, 0);
        check("rand_reset", m_pc, m_q.size(), m_err);
        for (int n = 0; n < 3000; n++) begin
            bit r, e, s, l, c, rt;
            int pin;
            r   = ($urandom_range(0, 99) == 0);
            e   = ($urandom_range(0, 99) < 45);
            s   = ($urandom_range(0, 99) < 20);
            l   = ($urandom_range(0, 99) < 12);
            c   = ($urandom_range(0, 99) < 18);
            rt  = ($urandom_range(0, 99) < 18);
            pin = $urandom_range(0, 31);
            step(r, e, s, l, c, rt, pin);
            model(r, e, s, l, c, rt, pin);
            check($sformatf("rand_%0d", n), m_pc, m_q.size(), m_err);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
